ps2_host_tx: RTL
================

# ps2_host_tx

Host-to-device PS/2 command transmitter, the send direction of the keyboard link. It sits beside the PS/2 receiver on the 50 MHz domain (`div[0]`) and lets the CPU, via the port controller, send commands such as 0xED (set LEDs), 0xF4 (enable) and 0xFF (reset) to the keyboard. It drives the open-drain PS/2 clock and data lines through output-enables, frames the byte with odd parity, and checks the device ACK and the protocol timeouts. While a send is in progress it tells the receiver to ignore traffic.

## Interface
- `INHIBIT_CYCLES`, default 5000: clock-inhibit hold (100 µs at 50 MHz).
- `START_TIMEOUT`, default 750000: limit from clock release to the first device falling edge (15 ms).
- `PACKET_TIMEOUT`, default 100000: limit from the first falling edge to the ACK (2 ms).
- `FILTER_LEN`, default 8: consecutive equal samples needed before the filtered clock changes.

- `clock50`  in  1  50 MHz clock; the single clock domain.
- `reset_n`  in  1  synchronous, active-low reset.
- `cmd_data`  in  8  command byte; sampled when a send is accepted.
- `cmd_send`  in  1  one-cycle request strobe.
- `busy`  out  1  transaction in progress.
- `rx_inhibit`  out  1  equals `busy`; receiver ignores frames while high.
- `cmd_done`  out  1  one-cycle completion pulse.
- `cmd_error`  out  1  valid with `cmd_done`; 1 means timeout or no ACK.
- `ps2_clk_i`  in  1  raw PS/2 clock pin, asynchronous.
- `ps2_dat_i`  in  1  raw PS/2 data pin, asynchronous.
- `ps2_clk_oe`  out  1  1 pulls the clock line low, 0 releases it.
- `ps2_dat_oe`  out  1  1 pulls the data line low, 0 releases it.

## Operation
- **Input conditioning**
  - `ps2_clk_i` and `ps2_dat_i` each pass through a 2-flop synchronizer.
  - The clock then goes through a filter: `clk_f` changes only after `FILTER_LEN` consecutive equal synchronized samples. Reset value of `clk_f` is 1.
  - `fall` = `clk_f` going 1→0. It is a one-cycle pulse.
- **State machine**
  - **IDLE**: all outputs 0. When `cmd_send`=1, latch `shreg` = {1'b1 (stop), ~^cmd_data (odd parity), cmd_data}, then go to INHIBIT. `busy` rises on the next edge.
  - **INHIBIT**: `clk_oe`=1 for `INHIBIT_CYCLES` cycles, then go to START.
  - **START**: `clk_oe`=1 and `dat_oe`=1 (start bit 0) for exactly 1 cycle, then go to WAIT_FIRST.
  - **WAIT_FIRST**: `clk_oe`=0, `dat_oe` held at 1. Timer runs to `START_TIMEOUT`; expiry goes to FAIL. On `fall`: set `dat_oe`=~shreg[0], shift, `bitcnt`=1, clear timer, go to SEND.
  - **SEND**: on each `fall`, set `dat_oe`=~shreg[0] and shift, `bitcnt`+1.
    - Falls 2–8 send data bits 1–7, fall 9 sends parity, fall 10 sends stop (line released).
    - After fall 10, go to WAIT_ACK.
  - **WAIT_ACK**: on fall 11, sample the synchronized data line. If it is 0, the ACK is good and the next state is WAIT_IDLE; otherwise go to FAIL.
  - **WAIT_IDLE**: wait until the synchronized data line and `clk_f` are both 1, then go to DONE.
  - **PACKET_TIMEOUT** applies from fall 1 through the end of WAIT_IDLE; expiry goes to FAIL.
  - **DONE / FAIL**: 1 cycle with `cmd_done`=1 and `cmd_error` = 0 (DONE) or 1 (FAIL), all line enables 0, then go to IDLE.
- `cmd_send` while `busy` is ignored: no queueing, no error.
- Reset: while `reset_n`=0 at an edge, the block returns to IDLE and every output (`busy`, `rx_inhibit`, `cmd_done`, `cmd_error`, `clk_oe`, `dat_oe`) is 0 after that edge. This applies mid-frame too; the lines are released immediately.
- Timers are 20-bit saturating counters. `bitcnt` is 4 bits.

## Timing
- Accept to `clk_oe`=1: 1 cycle. `clk_oe` stays high for exactly `INHIBIT_CYCLES`+1 cycles (inhibit plus START).
- Device falling edge to `dat_oe` update: 2 (sync) + `FILTER_LEN` + 1 cycles. This is well inside the device half-period of ≥30 µs.
- The ACK is sampled on the same cycle `fall` 11 is seen. `cmd_done` follows WAIT_IDLE by 1 cycle.
- FAIL asserts `cmd_done` exactly 1 cycle after timer expiry.
- `dat_oe` never changes except on `fall` or on a state entry.

## Structure
- Shared package `ps2_pkg` holds:
  - the state enum;
  - command constants (`PS2_CMD_SET_LED`=8'hED, `PS2_CMD_ENABLE`=8'hF4, `PS2_CMD_RESET`=8'hFF);
  - the 50 MHz timing defaults, shared with the receiver.
- One sub-module, `ps2_line_filter` (synchronizer plus filter plus fall detect), instantiated for the clock and reusable by the receiver. Data uses only the synchronizer.

## Test plan
- **Normal send**: send 0xED, device model clocks at 12 kHz and ACKs.
  - Line sequence must be 0,1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Expect `cmd_done`=1 with `cmd_error`=0, and `busy` low afterwards.
- **Parity 0**: send 0xF4 → parity bit 0; model checks odd parity and reports no errors.
- **No clocks**: device model never clocks (`START_TIMEOUT`=1000 in bench) → `cmd_done` with `cmd_error`=1 at exactly 1000 cycles after clock release; both enables 0.
- **No ACK**: device leaves data high on fall 11 → `cmd_error`=1. A `cmd_send` issued during busy is ignored and only one `cmd_done` is seen.
- **Glitch rejection**: a 3-cycle low glitch on the clock (`FILTER_LEN`=8) → no bit advance; the frame still completes correctly.
- **Mid-frame reset**: `reset_n`=0 for one cycle after fall 5 → all outputs 0 on the next edge. A subsequent send of 0xFF then completes cleanly.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 types, command bytes and 50 MHz timing defaults
package ps2_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_WAIT_FIRST,
    S_SEND,
    S_WAIT_ACK,
    S_WAIT_IDLE,
    S_DONE,
    S_FAIL
  } ps2_tx_state_t;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;

  localparam int PS2_INHIBIT_CYCLES = 5000;
  localparam int PS2_START_TIMEOUT  = 750000;
  localparam int PS2_PACKET_TIMEOUT = 100000;
  localparam int PS2_FILTER_LEN     = 8;
  localparam int PS2_TIMER_W        = 20;

  // Transmit order is LSB first: data[0..7], odd parity, then stop.
  function automatic logic [9:0] ps2_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - 2-flop synchronizer, run-length glitch filter and falling-edge pulse
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = PS2_FILTER_LEN
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic filt,
  output logic fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;

  // The filtered level flips only after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta <= 1'b1;
      sync <= 1'b1;
      filt <= 1'b1;
      cnt  <= '0;
      fall <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
      fall <= 1'b0;
      if (sync == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        filt <= sync;
        cnt  <= '0;
        fall <= filt;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - host-to-device PS/2 command transmitter with ACK and timeout checks
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int START_TIMEOUT  = PS2_START_TIMEOUT,
  parameter int PACKET_TIMEOUT = PS2_PACKET_TIMEOUT,
  parameter int FILTER_LEN     = PS2_FILTER_LEN
) (
  input  logic       clock50,
  input  logic       reset_n,
  input  logic [7:0] cmd_data,
  input  logic       cmd_send,
  output logic       busy,
  output logic       rx_inhibit,
  output logic       cmd_done,
  output logic       cmd_error,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam logic [PS2_TIMER_W-1:0] INH_LAST   = PS2_TIMER_W'(INHIBIT_CYCLES - 1);
  localparam logic [PS2_TIMER_W-1:0] START_LAST = PS2_TIMER_W'(START_TIMEOUT - 1);
  localparam logic [PS2_TIMER_W-1:0] PKT_LAST   = PS2_TIMER_W'(PACKET_TIMEOUT - 1);

  ps2_tx_state_t          state_q, state_d;
  logic [9:0]             shreg_q, shreg_d;
  logic [3:0]             bitcnt_q, bitcnt_d;
  logic [PS2_TIMER_W-1:0] timer_q, timer_d, timer_inc;
  logic                   dat_oe_q, dat_oe_d;

  logic clk_f;
  logic fall;
  logic dat_meta;
  logic dat_sync;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clk    (clock50),
    .reset_n(reset_n),
    .raw    (ps2_clk_i),
    .filt   (clk_f),
    .fall   (fall)
  );

  always_ff @(posedge clock50) begin
    if (!reset_n) begin
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      dat_meta <= ps2_dat_i;
      dat_sync <= dat_meta;
    end
  end

  always_ff @(posedge clock50) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      timer_q  <= '0;
      dat_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      timer_q  <= timer_d;
      dat_oe_q <= dat_oe_d;
    end
  end

  assign timer_inc = (timer_q == '1) ? timer_q : timer_q + PS2_TIMER_W'(1);

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    timer_d  = timer_q;
    dat_oe_d = dat_oe_q;

    case (state_q)
      S_IDLE: begin
        dat_oe_d = 1'b0;
        timer_d  = '0;
        if (cmd_send) begin
          shreg_d  = ps2_frame(cmd_data);
          bitcnt_d = '0;
          state_d  = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (timer_q == INH_LAST) begin
          timer_d  = '0;
          dat_oe_d = 1'b1;
          state_d  = S_START;
        end else begin
          timer_d = timer_inc;
        end
      end

      S_START: begin
        timer_d = '0;
        state_d = S_WAIT_FIRST;
      end

      S_WAIT_FIRST: begin
        if (fall) begin
          dat_oe_d = ~shreg_q[0];
          shreg_d  = {1'b1, shreg_q[9:1]};
          bitcnt_d = 4'd1;
          timer_d  = '0;
          state_d  = S_SEND;
        end else if (timer_q == START_LAST) begin
          dat_oe_d = 1'b0;
          state_d  = S_FAIL;
        end else begin
          timer_d = timer_inc;
        end
      end

      S_SEND: begin
        if (timer_q == PKT_LAST) begin
          dat_oe_d = 1'b0;
          state_d  = S_FAIL;
        end else begin
          timer_d = timer_inc;
          if (fall) begin
            dat_oe_d = ~shreg_q[0];
            shreg_d  = {1'b1, shreg_q[9:1]};
            bitcnt_d = bitcnt_q + 4'd1;
            // Fall 10 puts the stop bit (released line) out; the next fall carries the ACK.
            if (bitcnt_q == 4'd9) begin
              state_d = S_WAIT_ACK;
            end
          end
        end
      end

      S_WAIT_ACK: begin
        if (timer_q == PKT_LAST) begin
          dat_oe_d = 1'b0;
          state_d  = S_FAIL;
        end else begin
          timer_d = timer_inc;
          if (fall) begin
            bitcnt_d = bitcnt_q + 4'd1;
            dat_oe_d = 1'b0;
            state_d  = dat_sync ? S_FAIL : S_WAIT_IDLE;
          end
        end
      end

      S_WAIT_IDLE: begin
        if (timer_q == PKT_LAST) begin
          dat_oe_d = 1'b0;
          state_d  = S_FAIL;
        end else begin
          timer_d = timer_inc;
          if (dat_sync && clk_f) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE, S_FAIL: begin
        dat_oe_d = 1'b0;
        timer_d  = '0;
        state_d  = S_IDLE;
      end

      default: begin
        dat_oe_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign rx_inhibit = busy;
  assign cmd_done   = (state_q == S_DONE) || (state_q == S_FAIL);
  assign cmd_error  = (state_q == S_FAIL);
  assign ps2_clk_oe = (state_q == S_INHIBIT) || (state_q == S_START);
  assign ps2_dat_oe = dat_oe_q;

endmodule
